// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusyCpu,
        StBusyVid
    } state_e;

    typedef enum logic {
        GntCpu,
        GntVid
    } gnt_e;

    localparam logic [31:0] SwAddrDefault = 32'd256;
    localparam int unsigned CntW = 3;

    // The all-ones switch pattern reads back as zero.
    function automatic logic [1:0] sw_decode(input logic [1:0] sw);
        return (sw == 2'b11) ? 2'b00 : sw;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for slow asynchronous inputs such as board switches.
module sync2 #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one read-only memory between a CPU load port and
// a video fetch port, with a memory-mapped switch register.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned       ADDR_W  = 32,
    parameter int unsigned       DATA_W  = 32,
    parameter logic [ADDR_W-1:0] SW_ADDR = ADDR_W'(SwAddrDefault),
    parameter int unsigned       ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              switch1,
    input  logic              switch2,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ready,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q;
    gnt_e              last_grant_q;
    logic [CntW-1:0]   cnt_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] vid_rdata_q;
    logic              sel_sw_q;
    logic [1:0]        sw_val_q;
    logic [1:0]        sw_s;

    logic              done;
    logic              arb_open;
    logic              grant_cpu;
    logic              grant_vid;
    logic              accept;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] rd_data;

    sync2 #(
        .WIDTH(2)
    ) u_sync2 (
        .clk  (clk),
        .reset(reset),
        .d    ({switch1, switch2}),
        .q    (sw_s)
    );

    // The terminal busy cycle doubles as an arbitration slot, so accesses chain
    // without an idle bubble.
    always_comb begin
        done      = (state_q != StIdle) && (cnt_q == CntW'(1));
        arb_open  = !reset && ((state_q == StIdle) || done);
        grant_cpu = 1'b0;
        grant_vid = 1'b0;
        if (arb_open) begin
            if (cpu_req && vid_req) begin
                grant_cpu = (last_grant_q == GntVid);
                grant_vid = (last_grant_q == GntCpu);
            end else begin
                grant_cpu = cpu_req;
                grant_vid = vid_req;
            end
        end
        accept   = grant_cpu || grant_vid;
        acc_addr = grant_cpu ? cpu_addr : vid_addr;
        rd_data  = sel_sw_q ? DATA_W'(sw_decode(sw_val_q)) : mem_rdata;
    end

    assign cpu_ready  = grant_cpu;
    assign vid_ready  = grant_vid;
    assign cpu_rvalid = !reset && done && (state_q == StBusyCpu);
    assign vid_rvalid = !reset && done && (state_q == StBusyVid);
    assign cpu_rdata  = cpu_rvalid ? rd_data : cpu_rdata_q;
    assign vid_rdata  = vid_rvalid ? rd_data : vid_rdata_q;
    assign mem_addr   = mem_addr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= GntVid;
            cnt_q        <= '0;
            mem_addr_q   <= '0;
            cpu_rdata_q  <= '0;
            vid_rdata_q  <= '0;
            sel_sw_q     <= 1'b0;
            sw_val_q     <= 2'b00;
        end else begin
            if (cpu_rvalid) begin
                cpu_rdata_q <= rd_data;
            end
            if (vid_rvalid) begin
                vid_rdata_q <= rd_data;
            end
            if (accept) begin
                state_q      <= grant_cpu ? StBusyCpu : StBusyVid;
                last_grant_q <= grant_cpu ? GntCpu : GntVid;
                cnt_q        <= CntW'(ROM_LAT);
                sel_sw_q     <= (acc_addr == SW_ADDR);
                sw_val_q     <= sw_s;
                // Switch reads leave the memory address untouched.
                if (acc_addr != SW_ADDR) begin
                    mem_addr_q <= acc_addr;
                end
            end else if (done) begin
                state_q <= StIdle;
                cnt_q   <= '0;
            end else if (state_q != StIdle) begin
                cnt_q <= cnt_q - CntW'(1);
            end
        end
    end

endmodule
